mul_share_arbiter: RTL and testbench
====================================

Name: mul_share_arbiter

Overview:
- Shares one 32x32->32 pipelined multiplier cell (low 32 bits of the product) between NUM_REQ CPU requesters in the MPSoC.
- Round-robin issue, at most one operation per cycle, fully pipelined.
- The requester tag travels alongside the cell latency, and the result is returned registered to the owner.
- A drain handshake lets system control quiesce the shared cell, for example before a CPU reset or reconfiguration.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MUL_LATENCY, 1, clock cycles from cell inputs to valid mul_cell_result.
- DATA_W, 32, operand and result width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_src1  in  NUM_REQ*DATA_W  flattened operand A; requester i occupies bits [i*DATA_W +: DATA_W].
- req_src2  in  NUM_REQ*DATA_W  flattened operand B, same packing as req_src1.
- req_ready  out  NUM_REQ  one-hot grant; an operation is accepted when req_valid[i] and req_ready[i] are both high.
- resp_valid  out  NUM_REQ  one-hot, single-cycle result strobe.
- resp_result  out  DATA_W  result; valid only with resp_valid.
- mul_src1  out  DATA_W  to cell operand A.
- mul_src2  out  DATA_W  to cell operand B.
- mul_cell_result  in  DATA_W  from cell.
- drain_req  in  1  level request to stop issuing.
- drain_ack  out  1  high while in DRAINED state.
- busy  out  1  at least one operation in flight or responding.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values:
  - rr_ptr = 0.
  - Tag pipeline valid bits all 0.
  - resp_valid = 0, resp_result = 0.
  - mul_src1 = mul_src2 = 0.
  - drain_ack = 0, busy = 0.
  - FSM = RUN.
- Arbitration (combinational within the cycle):
  - In RUN, grant goes to the first i with req_valid[i] set, searching circularly from rr_ptr.
  - req_ready is one-hot for that i; it is all zero if no request or not in RUN.
  - req_ready never asserts for a requester whose req_valid is low.
- Pointer update: on an accepted grant to i, rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- Cell drive:
  - mul_src1/mul_src2 are combinational muxes of the granted requester's operands.
  - With no grant they hold the last issued operands from a register, so the cell sees no toggling when idle.
  - The cell samples on the grant edge.
- Tag pipeline:
  - MUL_LATENCY-stage shift register carrying {valid, id}.
  - Stage 0 loads {1, i} on an accepted grant, else {0, x}.
- Response:
  - When the last stage is valid, the next edge registers resp_result <= mul_cell_result and resp_valid <= onehot(id).
  - Total latency is MUL_LATENCY+1 cycles from the accept edge (2 cycles by default).
  - One response per cycle maximum; back-to-back grants give back-to-back responses in issue order.
- Arithmetic: the arbiter performs none. The result is exactly the cell output, i.e. (src1*src2) mod 2^32, unsigned low word (equal to the signed low word).
- Requester obligations:
  - Hold req_valid and operands stable until accepted.
  - A requester may re-request in the cycle after acceptance; multiple outstanding ops per requester are legal.
- busy = OR of tag-pipeline valid bits OR any resp_valid bit.
- FSM:
  - RUN -> DRAIN on drain_req=1. The grant is suppressed in the same cycle drain_req is sampled high, i.e. no grant is combinationally issued while drain_req=1.
  - DRAIN: no grants; in-flight ops complete normally. DRAIN -> DRAINED when busy=0.
  - DRAINED: drain_ack=1, no grants. DRAINED -> RUN when drain_req=0; grants resume in the following cycle.
  - DRAIN with drain_req deasserted before empty -> RUN directly.
- Boundary conditions:
  - All requesters valid: strict rotation 0,1,2,3,0...
  - Single requester: granted every cycle.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Reset mid-operation clears all in-flight tags; no response is produced for them. The bench ties the cell's reset_n to ~reset.
  - A drain_req pulse of one cycle still completes a RUN->DRAIN->(RUN) pass with no lost or duplicated responses.

Test Plan:
- Single op: req0 src1=0x00010003, src2=0x00020005 accepted at T -> resp_valid=0001 at T+2, resp_result=0x000B000F.
- Wrap/overflow: req1 src1=0xFFFFFFFF, src2=0xFFFFFFFF -> resp_valid=0010, resp_result=0x00000001. Also src1=0x80000000, src2=2 -> result 0x00000000.
- Contention: all four valid continuously from reset -> grants 0,1,2,3,0,1 on consecutive cycles. Responses in the same order, each 2 cycles after its grant, one per cycle.
- Fairness restart: rr_ptr=2, only req0 and req3 valid -> req3 granted first, then req0.
- Drain: 3 back-to-back ops issued, then drain_req=1 -> no further req_ready. All 3 responses delivered, then drain_ack=1 the cycle after busy falls. Drop drain_req -> grants resume next cycle.
- Reset mid-flight: grant at T, reset=1 at T+1 -> no resp_valid at T+2. All outputs at reset values; rr_ptr=0 afterwards.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined 32x32 multiplier cell between
// several requesters, with tag tracking and a drain/quiesce handshake.
module mul_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 1,
  parameter int DATA_W      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_src1,
  input  logic [NUM_REQ*DATA_W-1:0] req_src2,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_result,
  output logic [DATA_W-1:0]         mul_src1,
  output logic [DATA_W-1:0]         mul_src2,
  input  logic [DATA_W-1:0]         mul_cell_result,
  input  logic                      drain_req,
  output logic                      drain_ack,
  output logic                      busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LP_LAST = PTR_W'(NUM_REQ - 1);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_DRAIN   = 2'd1;
  localparam logic [1:0] ST_DRAINED = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic               w_can_grant;
  logic               w_found;
  logic               w_gnt_ok;
  logic [PTR_W-1:0]   w_gnt_id;
  logic [NUM_REQ-1:0] w_ge_mask;
  logic [NUM_REQ-1:0] w_hi;
  logic [DATA_W-1:0]  w_op1 [NUM_REQ];
  logic [DATA_W-1:0]  w_op2 [NUM_REQ];
  logic [DATA_W-1:0]  r_src1;
  logic [DATA_W-1:0]  r_src2;
  logic [MUL_LATENCY-1:0] r_tag_v;
  logic [PTR_W-1:0]   r_tag_id [MUL_LATENCY];
  logic [NUM_REQ-1:0] w_resp_oh;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [DATA_W-1:0]  r_resp_result;
  logic               w_busy;

  assign w_can_grant = (r_state == ST_RUN) && !drain_req;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_op1[i] = req_src1[i*DATA_W +: DATA_W];
      w_op2[i] = req_src2[i*DATA_W +: DATA_W];
    end
  end

  // Circular search: first requester at or above the pointer, else lowest.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_ge_mask[i] = (PTR_W'(i) >= r_rr_ptr);
    end
    w_hi     = req_valid & w_ge_mask;
    w_found  = 1'b0;
    w_gnt_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_hi[i]) begin
        w_found  = 1'b1;
        w_gnt_id = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i]) begin
        w_found  = 1'b1;
        w_gnt_id = PTR_W'(i);
      end
    end
  end

  assign w_gnt_ok = w_found && w_can_grant;

  always_comb begin
    req_ready = '0;
    if (w_gnt_ok) req_ready[w_gnt_id] = 1'b1;
  end

  // Idle cycles replay the last operands so the cell inputs stay quiet.
  assign mul_src1 = w_gnt_ok ? w_op1[w_gnt_id] : r_src1;
  assign mul_src2 = w_gnt_ok ? w_op2[w_gnt_id] : r_src2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr <= '0;
      r_src1   <= '0;
      r_src2   <= '0;
    end else if (w_gnt_ok) begin
      r_rr_ptr <= (w_gnt_id == LP_LAST) ? '0 : w_gnt_id + PTR_W'(1);
      r_src1   <= w_op1[w_gnt_id];
      r_src2   <= w_op2[w_gnt_id];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag_v <= '0;
    end else begin
      r_tag_v[0] <= w_gnt_ok;
      for (int s = 1; s < MUL_LATENCY; s++) begin
        r_tag_v[s] <= r_tag_v[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_tag_id[0] <= w_gnt_id;
    for (int s = 1; s < MUL_LATENCY; s++) begin
      r_tag_id[s] <= r_tag_id[s-1];
    end
  end

  always_comb begin
    w_resp_oh = '0;
    w_resp_oh[r_tag_id[MUL_LATENCY-1]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_valid  <= '0;
      r_resp_result <= '0;
    end else begin
      r_resp_valid <= r_tag_v[MUL_LATENCY-1] ? w_resp_oh : '0;
      if (r_tag_v[MUL_LATENCY-1]) r_resp_result <= mul_cell_result;
    end
  end

  assign resp_valid  = r_resp_valid;
  assign resp_result = r_resp_result;
  assign w_busy      = (|r_tag_v) || (|r_resp_valid);
  assign busy        = w_busy;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN: begin
        if (drain_req) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!drain_req)  w_state_nxt = ST_RUN;
        else if (!w_busy) w_state_nxt = ST_DRAINED;
      end
      ST_DRAINED: begin
        if (!drain_req) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  assign drain_ack = (r_state == ST_DRAINED);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized scoreboard bench for mul_share_arbiter with a registered
// behavioural multiplier cell standing in for the shared unit.
module tb_mul_share_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;

  typedef struct {
    int          id;
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset;
  logic [NR-1:0]  pend;
  logic [DW-1:0]  opa [NR];
  logic [DW-1:0]  opb [NR];
  logic [DW-1:0]  expr [NR];
  logic           drn;

  logic [NR*DW-1:0] req_src1;
  logic [NR*DW-1:0] req_src2;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    resp_valid;
  logic [DW-1:0]    resp_result;
  logic [DW-1:0]    mul_src1;
  logic [DW-1:0]    mul_src2;
  logic [DW-1:0]    cell_q;
  logic             drain_ack;
  logic             busy;

  exp_t sb [$];
  exp_t mon_e;
  int   bq [$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_ptr;
  int   m_st;
  logic [DW-1:0] last_a;
  logic [DW-1:0] last_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_src1[i*DW +: DW] = opa[i];
      req_src2[i*DW +: DW] = opb[i];
    end
  end

  // Shared cell: one-cycle registered low-word multiply, reset_n = ~reset.
  always_ff @(posedge clk) begin
    if (reset) cell_q <= '0;
    else       cell_q <= mul_src1 * mul_src2;
  end

  mul_share_arbiter #(
    .NUM_REQ(NR), .MUL_LATENCY(1), .DATA_W(DW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(pend),
    .req_src1(req_src1),
    .req_src2(req_src2),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_result(resp_result),
    .mul_src1(mul_src1),
    .mul_src2(mul_src2),
    .mul_cell_result(cell_q),
    .drain_req(drn),
    .drain_ack(drain_ack),
    .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'h0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic load_x(input int i, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e);
    pend[i] = 1'b1;
    opa[i]  = a;
    opb[i]  = b;
    expr[i] = e;
  endtask

  task automatic fill(input logic [NR-1:0] mask);
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < NR; i++) begin
      if (mask[i] && !pend[i]) begin
        a = rnd_op();
        b = rnd_op();
        load_x(i, a, b, a * b);
      end
    end
  endtask

  // Reference: round-robin from a pointer, drain state from the rules.
  task automatic step();
    int g;
    bit be;
    logic [NR-1:0] er;
    exp_t e;
    @(negedge clk);
    while (bq.size() != 0 && bq[0] < cyc) void'(bq.pop_front());
    g = -1;
    if (m_st == 0 && !drn) begin
      for (int k = 0; k < NR; k++) begin
        if (g < 0 && pend[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    be = 1'b0;
    foreach (bq[k]) if (bq[k] - 2 < cyc && cyc <= bq[k]) be = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("drain_ack", 32'(drain_ack), 32'(m_st == 2));
    chk("busy", 32'(busy), 32'(be));
    if (g >= 0) begin
      last_a = opa[g];
      last_b = opb[g];
      e.id  = g;
      e.res = expr[g];
      e.cyc = cyc + 2;
      sb.push_back(e);
      bq.push_back(cyc + 2);
      m_ptr = (g + 1) % NR;
    end
    chk("mul_src1", mul_src1, last_a);
    chk("mul_src2", mul_src2, last_b);
    case (m_st)
      0: if (drn) m_st = 1;
      1: if (!drn) m_st = 0; else if (!be) m_st = 2;
      default: if (!drn) m_st = 0;
    endcase
    @(posedge clk);
    #1;
    if (g >= 0) pend[g] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic hard_reset();
    reset = 1'b1;
    pend  = '0;
    drn   = 1'b0;
    sb.delete();
    bq.delete();
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    m_ptr  = 0;
    m_st   = 0;
    last_a = '0;
    last_b = '0;
    @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_result", resp_result, 32'h0);
    chk("rst_mul_src1", mul_src1, 32'h0);
    chk("rst_mul_src2", mul_src2, 32'h0);
    chk("rst_drain_ack", 32'(drain_ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
  endtask

  always begin
    @(posedge clk);
    #2;
    if (resp_valid !== '0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: actual resp_valid %b required 0000 (cycle %0d)",
                 resp_valid, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("resp_valid", 32'(resp_valid), 32'(4'b0001 << mon_e.id));
        chk("resp_result", resp_result, mon_e.res);
        chk("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL resp_missing: actual none required id %0d at cycle %0d (now %0d)",
               mon_e.id, mon_e.cyc, cyc);
    end
  end

  initial begin
    int t;
    reset = 1'b1;
    pend  = '0;
    drn   = 1'b0;
    for (int i = 0; i < NR; i++) begin
      opa[i]  = '0;
      opb[i]  = '0;
      expr[i] = '0;
    end
    #1;
    hard_reset();

    load_x(0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F);
    step();
    idle(3);
    load_x(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    step();
    load_x(1, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000);
    step();
    idle(3);

    hard_reset();
    repeat (8) begin
      fill(4'hF);
      step();
    end
    idle(4);

    repeat (5) begin
      fill(4'b0100);
      step();
    end
    idle(3);

    fill(4'b0010);
    step();
    fill(4'b1001);
    step();
    step();
    idle(3);

    fill(4'b0111);
    step();
    step();
    step();
    drn = 1'b1;
    fill(4'b1000);
    idle(6);
    drn = 1'b0;
    idle(4);

    fill(4'hF);
    step();
    drn = 1'b1;
    fill(4'hF);
    step();
    drn = 1'b0;
    repeat (4) begin
      fill(4'hF);
      step();
    end
    idle(4);

    repeat (1500) begin
      fill(4'($urandom));
      if ($urandom_range(0, 19) == 0) drn = ~drn;
      step();
    end
    drn = 1'b0;
    idle(8);

    load_x(2, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340);
    step();
    hard_reset();
    fill(4'hF);
    step();
    idle(4);

    t = 0;
    while ((sb.size() != 0 || pend != '0) && t < 40) begin
      step();
      t++;
    end
    if (sb.size() != 0 || pend != '0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: actual %0d outstanding required 0",
               sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
